song_writer: RTL and testbench
==============================

Name: song_writer

Overview:
- Records a user-entered tune into an internal note memory. Each entry is a note code plus a duration in slow ticks.
- Exposes a registered read port so song_reader-style playback logic consumes exactly what was written. It is the writer end of the song memory interface.
- Sits beside the game datapath. Note codes come from switches_in, the capture button is a raw push button, and tick is the DIV256-style slow enable.

Parameters:
- DEPTH, 32, number of note entries (power of two)
- ADDR_W, 5, log2(DEPTH)
- NOTE_W, 4, note code width; code 0 = rest
- DUR_W, 8, duration width in ticks

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rec  input  1  record enable (level, already synchronous)
- cap  input  1  raw capture push button (asynchronous, active-high)
- tick  input  1  one-cycle slow enable
- note_in  input  NOTE_W  note code sampled at capture press
- rd_addr  input  ADDR_W  playback read address
- rd_data  output  NOTE_W+DUR_W  {note, dur} at rd_addr, 1-cycle latency
- song_len  output  ADDR_W+1  number of valid entries
- wr_pulse  output  1  one-cycle strobe per committed entry
- busy  output  1  high in HOLD/COMMIT
- full  output  1  song_len == DEPTH

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; song_len=0; rd_data=0; wr_pulse=0; busy=0; full=0.
  - Memory contents are not reset.
- cap input conditioning:
  - cap passes through a 2-FF synchronizer, giving cap_s.
  - cap_rise = cap_s & ~cap_s_d.
  - Response to a cap edge is 3 clk later.
- State machine:
  - IDLE: rec rising edge → clear song_len to 0, go to ARMED. cap is ignored.
  - ARMED: cap_rise → latch note_in into note_r, set dur=0, go to HOLD.
  - HOLD: each tick with cap_s=1 increments dur, saturating at 2^DUR_W-1. cap_s=0 → go to COMMIT. A tick in the same cycle cap_s reads 0 is not counted.
  - COMMIT (1 cycle): write mem[song_len] = {note_r, (dur==0 ? 1 : dur)}; increment song_len; pulse wr_pulse. Next state is FULL if the new song_len == DEPTH, else ARMED.
  - FULL: full=1; cap is ignored. rec falling → IDLE.
- rec falls in any state:
  - Go to IDLE next cycle.
  - An entry in HOLD, or in COMMIT on that same cycle, is discarded; no write, no wr_pulse.
  - song_len keeps its last value so the song can be played back.
- rec already high at reset release: no recording starts until a fresh rec rising edge.
- A cap held across IDLE→ARMED does not start a note; a fresh rising edge is required.
- Read port:
  - rd_data <= mem[rd_addr] every cycle.
  - Read and write to the same address in the same cycle returns the old data.
  - Contents at rd_addr >= song_len are don't-care.
- A note code 0 entered by the user is stored as a rest, same as any other code.

Optional Feature:
- Macro: SONG_WRITER_REST_EN.
- Defined:
  - In ARMED, after at least one committed entry, count ticks since release into gap (saturating, DUR_W).
  - On the next cap_rise with gap>0, first execute REST_COMMIT: write {0, gap}, song_len++, wr_pulse. Then go to HOLD for the pressed note; its commit is normal.
  - If REST_COMMIT fills memory, go to FULL and drop the note.
  - gap is cleared on each commit and on rec rise.
- Undefined: gaps are not recorded; REST_COMMIT state and gap counter are absent.

Decomposition:
- Shared package song_pkg:
  - constants NOTE_W, DUR_W, NOTE_REST=0
  - entry struct {note, dur}
  - state enum IDLE/ARMED/HOLD/COMMIT/REST_COMMIT/FULL
- Shared with song_reader: entry format and the rest code.
- One sub-module: cap_sync_edge (2-FF synchronizer plus rising-edge detect), reusable for other push buttons.

Test Plan:
- Reset and first note:
  - Stimulus: rst low mid-HOLD.
  - Response: all outputs 0, song_len=0; after release no entry is written until rec rises again.
- Basic note:
  - Stimulus: rec rise; note_in=5; hold cap across 3 ticks; release.
  - Response: one wr_pulse; song_len=1; rd_addr=0 gives rd_data={5,3} one cycle later.
- Zero and saturating durations:
  - Stimulus: press and release between ticks; then press with DUR_W=8 held for 300 ticks.
  - Response: entries {n,1} and {n,255}.
- Full (DEPTH=4):
  - Stimulus: commit 4 notes, then press again.
  - Response: full=1 after 4th wr_pulse; 5th press gives no wr_pulse; song_len=4.
- Abort:
  - Stimulus: rec falls during HOLD, and separately on the COMMIT cycle.
  - Response: no write; song_len unchanged; state IDLE.
- SONG_WRITER_REST_EN:
  - Stimulus: note 3 held 2 ticks, 4-tick gap, note 7 held 1 tick.
  - Response: entries {3,2},{0,4},{7,1}; song_len=3.
  - Without the macro: entries {3,2},{7,1}; song_len=2.

Source files
------------

// File: rtl/song_pkg.sv
// Shared song memory definitions: entry layout, rest code and writer FSM states.
// The writer and the reader both use this entry format and rest code.
package song_pkg;
  localparam int NOTE_W = 4;
  localparam int DUR_W  = 8;
  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE, ARMED, HOLD, COMMIT, REST_COMMIT, FULL
  } state_t;
endpackage

// File: rtl/song_writer_if.sv
// Song writer bus: record controls, capture inputs and the playback read port.
interface song_writer_if #(
  parameter int ADDR_W = 5,
  parameter int NOTE_W = 4,
  parameter int DUR_W  = 8
);
  logic                    rec;
  logic                    cap;
  logic                    tick;
  logic [NOTE_W-1:0]       note_in;
  logic [ADDR_W-1:0]       rd_addr;
  logic [NOTE_W+DUR_W-1:0] rd_data;
  logic [ADDR_W:0]         song_len;
  logic                    wr_pulse;
  logic                    busy;
  logic                    full;

  modport master (output rec, cap, tick, note_in, rd_addr,
                  input  rd_data, song_len, wr_pulse, busy, full);
  modport slave  (input  rec, cap, tick, note_in, rd_addr,
                  output rd_data, song_len, wr_pulse, busy, full);
endinterface

// File: rtl/song_writer_cap_sync.sv
// cap_sync_edge: 2-FF synchronizer plus rising-edge detect for raw push buttons.
module cap_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise
);
  logic meta, lvl_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta  <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      meta  <= din;
      lvl   <= meta;
      lvl_d <= lvl;
    end
  end

  assign rise = lvl & ~lvl_d;
endmodule

// File: rtl/song_writer.sv
// Tune recorder: captures {note, duration} entries into a song memory with a registered read port.
// Define SONG_WRITER_REST_EN to also record the gaps between notes as rest entries.
module song_writer #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NOTE_W = song_pkg::NOTE_W,
  parameter int DUR_W  = song_pkg::DUR_W
) (
  input logic         clk,
  input logic         rst,
  song_writer_if.slave bus
);
  import song_pkg::*;

  localparam logic [DUR_W-1:0]  DUR_MAX = '1;
  localparam logic [DUR_W-1:0]  DUR_ONE = DUR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);

  logic cap_s, cap_rise;

  cap_sync_edge u_cap (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.cap),
    .lvl  (cap_s),
    .rise (cap_rise)
  );

  state_t                  state;
  logic                    rec_d;
  logic [NOTE_W-1:0]       note_r;
  logic [DUR_W-1:0]        dur;
  logic [ADDR_W:0]         song_len;
  logic                    wr_pulse;
  logic                    we;
  logic [NOTE_W+DUR_W-1:0] wdata;
  logic [NOTE_W+DUR_W-1:0] mem [DEPTH];
`ifdef SONG_WRITER_REST_EN
  logic [DUR_W-1:0]        gap;
`endif

  // A falling rec suppresses the write even on the commit cycle itself.
  always_comb begin
    we    = 1'b0;
    wdata = {note_r, (dur == '0) ? DUR_ONE : dur};
    if (bus.rec && state == COMMIT) we = 1'b1;
`ifdef SONG_WRITER_REST_EN
    if (bus.rec && state == REST_COMMIT) begin
      we    = 1'b1;
      wdata = {NOTE_W'(NOTE_REST), gap};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (we) mem[song_len[ADDR_W-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.rd_data <= '0;
    else      bus.rd_data <= mem[bus.rd_addr];
  end

  // rec_d resets high so a rec already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rec_d    <= 1'b1;
      note_r   <= '0;
      dur      <= '0;
      song_len <= '0;
      wr_pulse <= 1'b0;
`ifdef SONG_WRITER_REST_EN
      gap      <= '0;
`endif
    end else begin
      rec_d    <= bus.rec;
      wr_pulse <= 1'b0;
      if (state != IDLE && !bus.rec) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (bus.rec && !rec_d) begin
            song_len <= '0;
`ifdef SONG_WRITER_REST_EN
            gap      <= '0;
`endif
            state    <= ARMED;
          end
          ARMED: begin
`ifdef SONG_WRITER_REST_EN
            if (bus.tick && song_len != '0 && gap != DUR_MAX) gap <= gap + DUR_ONE;
`endif
            if (cap_rise) begin
              note_r <= bus.note_in;
              dur    <= '0;
`ifdef SONG_WRITER_REST_EN
              state  <= (gap != '0) ? REST_COMMIT : HOLD;
`else
              state  <= HOLD;
`endif
            end
          end
          HOLD: begin
            if (!cap_s) state <= COMMIT;
            else if (bus.tick && dur != DUR_MAX) dur <= dur + DUR_ONE;
          end
          COMMIT: begin
            song_len <= song_len + LEN_ONE;
            wr_pulse <= 1'b1;
`ifdef SONG_WRITER_REST_EN
            gap      <= '0;
`endif
            state    <= (song_len + LEN_ONE == LEN_MAX) ? FULL : ARMED;
          end
`ifdef SONG_WRITER_REST_EN
          // The pressed note proceeds to HOLD unless the rest consumed the last slot.
          REST_COMMIT: begin
            song_len <= song_len + LEN_ONE;
            wr_pulse <= 1'b1;
            gap      <= '0;
            state    <= (song_len + LEN_ONE == LEN_MAX) ? FULL : HOLD;
          end
`endif
          FULL:    state <= FULL;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.song_len = song_len;
  assign bus.wr_pulse = wr_pulse;
  assign bus.busy     = (state == HOLD) || (state == COMMIT) || (state == REST_COMMIT);
  assign bus.full     = (song_len == LEN_MAX);
endmodule

// File: tb/tb_song_writer.sv
// Self-checking bench for song_writer (DEPTH=4) against a queue-based model of the song.
module tb_song_writer;
  import song_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef SONG_WRITER_REST_EN
  localparam bit REST = 1'b1;
`else
  localparam bit REST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  song_writer_if #(.ADDR_W(AW), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) sif ();

  song_writer #(.DEPTH(DEPTH), .ADDR_W(AW), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  entry_t model[$];

  always @(negedge clk) if (sif.wr_pulse === 1'b1) pulses++;

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_rec();
    sif.rec = 1'b0; cyc(2);
    sif.rec = 1'b1; cyc(2);
    model.delete();
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      sif.tick = 1'b1; cyc(1);
      sif.tick = 1'b0; cyc(1);
    end
  endtask

  task automatic press(logic [NOTE_W-1:0] n);
    sif.note_in = n; sif.cap = 1'b1; cyc(6);
  endtask

  task automatic release_cap();
    sif.cap = 1'b0; cyc(7);
  endtask

  function automatic logic [DUR_W-1:0] sat(int t);
    return (t > 255) ? 8'd255 : DUR_W'(t);
  endfunction

  // Song as the user would expect it: gaps become rests, zero holds last one tick.
  function automatic void model_add(logic [NOTE_W-1:0] n, int t, int g);
    if (model.size() == DEPTH) return;
    if (REST && model.size() > 0 && g > 0) begin
      model.push_back('{NOTE_REST, sat(g)});
      if (model.size() == DEPTH) return;
    end
    model.push_back('{n, (t == 0) ? DUR_W'(1) : sat(t)});
  endfunction

  task automatic play(logic [NOTE_W-1:0] n, int t, int g);
    ticks(g);
    press(n);
    ticks(t);
    release_cap();
    model_add(n, t, g);
  endtask

  task automatic read_entry(int a, output logic [NOTE_W+DUR_W-1:0] d);
    sif.rd_addr = AW'(a);
    cyc(1);
    d = sif.rd_data;
  endtask

  task automatic test_reset();
    logic [NOTE_W+DUR_W-1:0] d;
    int p0;
    rst = 1'b1; sif.rec = 0; sif.cap = 0; sif.tick = 0; sif.note_in = 0; sif.rd_addr = 0;
    #1 rst = 1'b0;
    cyc(2);
    checks++;
    if ({sif.rd_data, sif.song_len, sif.wr_pulse, sif.busy, sif.full} !== '0) begin
      errors++; $display("FAIL reset_state: got %h required 0",
        {sif.rd_data, sif.song_len, sif.wr_pulse, sif.busy, sif.full});
    end
    rst = 1'b1;
    start_rec();
    play(4'd1, 1, 0);
    press(4'd9); ticks(1);
    checks++;
    if (sif.busy !== 1'b1) begin errors++; $display("FAIL reset_hold_busy: got %b required 1", sif.busy); end
    rst = 1'b0;
    #1;
    checks++;
    if (sif.song_len !== '0 || sif.busy !== 1'b0 || sif.full !== 1'b0 || sif.rd_data !== '0) begin
      errors++; $display("FAIL reset_mid_hold: len %0d busy %b full %b data %h required all 0",
        sif.song_len, sif.busy, sif.full, sif.rd_data);
    end
    cyc(2);
    rst = 1'b1;
    p0 = pulses;
    cyc(3);
    release_cap();
    press(4'd2); release_cap();
    checks++;
    if (pulses != p0 || sif.song_len !== '0 || sif.busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_rec_edge: pulses %0d len %0d busy %b required 0 0 0",
        pulses - p0, sif.song_len, sif.busy);
    end
    read_entry(0, d);
    d = d;
  endtask

  task automatic test_basic();
    logic [NOTE_W+DUR_W-1:0] d;
    int p0;
    start_rec();
    p0 = pulses;
    play(4'd5, 3, 0);
    read_entry(0, d);
    checks++;
    if (pulses - p0 != 1 || sif.song_len !== 3'd1) begin
      errors++; $display("FAIL basic_commit: pulses %0d len %0d required 1 1", pulses - p0, sif.song_len);
    end
    checks++;
    if (d !== 12'h503) begin errors++; $display("FAIL basic_entry: got %h required 503", d); end
  endtask

  task automatic test_durations();
    logic [NOTE_W+DUR_W-1:0] d;
    start_rec();
    play(4'd6, 0, 0);
    play(4'd0, 300, 0);
    read_entry(0, d);
    checks++;
    if (d !== 12'h601) begin errors++; $display("FAIL dur_zero: got %h required 601", d); end
    read_entry(1, d);
    checks++;
    if (d !== 12'h0ff) begin errors++; $display("FAIL dur_saturate: got %h required 0ff", d); end
  endtask

  task automatic test_full();
    int p0;
    start_rec();
    for (int i = 0; i < DEPTH - 1; i++) play(4'(i + 10), 1, 0);
    checks++;
    if (sif.full !== 1'b0) begin errors++; $display("FAIL full_early: got %b required 0", sif.full); end
    play(4'd14, 2, 0);
    checks++;
    if (sif.full !== 1'b1 || sif.song_len !== 3'd4) begin
      errors++; $display("FAIL full_set: full %b len %0d required 1 4", sif.full, sif.song_len);
    end
    p0 = pulses;
    press(4'd3); ticks(1); release_cap();
    checks++;
    if (pulses != p0 || sif.song_len !== 3'd4 || sif.busy !== 1'b0) begin
      errors++; $display("FAIL full_ignore: pulses %0d len %0d busy %b required 0 4 0",
        pulses - p0, sif.song_len, sif.busy);
    end
  endtask

  task automatic test_abort();
    logic [NOTE_W+DUR_W-1:0] d;
    int p0;
    start_rec();
    play(4'd4, 2, 0);
    p0 = pulses;
    press(4'd6); ticks(1);
    sif.rec = 1'b0; cyc(3);
    checks++;
    if (sif.busy !== 1'b0 || sif.song_len !== 3'd1) begin
      errors++; $display("FAIL abort_hold: busy %b len %0d required 0 1", sif.busy, sif.song_len);
    end
    release_cap();
    checks++;
    if (pulses != p0) begin errors++; $display("FAIL abort_hold_pulse: got %0d required 0", pulses - p0); end
    start_rec();
    play(4'd4, 2, 0);
    p0 = pulses;
    press(4'd8); ticks(1);
    sif.cap = 1'b0; cyc(3);
    sif.rec = 1'b0; cyc(5);
    checks++;
    if (pulses != p0 || sif.song_len !== 3'd1 || sif.busy !== 1'b0) begin
      errors++; $display("FAIL abort_commit: pulses %0d len %0d busy %b required 0 1 0",
        pulses - p0, sif.song_len, sif.busy);
    end
    press(4'd9); release_cap();
    read_entry(0, d);
    checks++;
    if (pulses != p0 || d !== 12'h402) begin
      errors++; $display("FAIL abort_idle: pulses %0d entry %h required 0 402", pulses - p0, d);
    end
  endtask

  task automatic test_rest_gap();
    logic [NOTE_W+DUR_W-1:0] d;
    logic [NOTE_W+DUR_W-1:0] exp_e [3];
    int exp_n;
    start_rec();
    play(4'd3, 2, 0);
    play(4'd7, 1, 4);
    if (REST) begin exp_n = 3; exp_e[0] = 12'h302; exp_e[1] = 12'h004; exp_e[2] = 12'h701; end
    else      begin exp_n = 2; exp_e[0] = 12'h302; exp_e[1] = 12'h701; exp_e[2] = '0; end
    checks++;
    if (int'(sif.song_len) != exp_n) begin
      errors++; $display("FAIL rest_len: got %0d required %0d", sif.song_len, exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      read_entry(i, d);
      checks++;
      if (d !== exp_e[i]) begin errors++; $display("FAIL rest_entry%0d: got %h required %h", i, d, exp_e[i]); end
    end
  endtask

  task automatic test_random();
    logic [NOTE_W+DUR_W-1:0] d;
    int p0, k;
    for (int r = 0; r < 8; r++) begin
      start_rec();
      p0 = pulses;
      k = $urandom_range(1, 5);
      for (int i = 0; i < k; i++)
        play(4'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom_range(0, 3));
      checks++;
      if (int'(sif.song_len) != model.size() || pulses - p0 != model.size() ||
          sif.full !== (model.size() == DEPTH)) begin
        errors++; $display("FAIL rand%0d_len: len %0d pulses %0d full %b required %0d",
          r, sif.song_len, pulses - p0, sif.full, model.size());
      end
      for (int i = 0; i < model.size(); i++) begin
        read_entry(i, d);
        checks++;
        if (d !== model[i]) begin
          errors++; $display("FAIL rand%0d_entry%0d: got %h required %h", r, i, d, model[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_durations();
    test_full();
    test_abort();
    test_rest_gap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
